// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the OBI-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bridge_state_t;

  localparam int unsigned   BE_WIDTH               = 4;
  localparam logic [BE_WIDTH-1:0] BE_FULL          = 4'hF;
  localparam int unsigned   TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int unsigned   TIMEOUT_CNT_WIDTH      = 16;

endpackage

// File: rtl/obi_to_apb_bridge.sv
// Single-outstanding req/gnt/rvalid to APB3 master bridge.
// Define APB_BRIDGE_TIMEOUT_EN to error out an ACCESS phase stalled for TIMEOUT_CYCLES.
module obi_to_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [BE_WIDTH-1:0]       be_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  if (APB_DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0 ||
      TIMEOUT_CYCLES >= (1 << TIMEOUT_CNT_WIDTH)) begin : g_bad_cfg
    $error("obi_to_apb_bridge: unsupported parameter combination");
  end

  bridge_state_t             state_q, state_d;
  logic [APB_DATA_WIDTH-1:0] rdata_d;
  logic                      err_d;
  logic                      be_err_c;

  // Grant is only offered from IDLE and never while reset is applied.
  assign gnt_o    = rst_ni & req_i & (state_q == IDLE);
  assign be_err_c = we_i & (be_i != BE_FULL);

`ifdef APB_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_CNT_WIDTH-1:0] wait_cnt_q;
  logic                         timeout_c;

  // Counts ACCESS cycles without pready; zero whenever not in ACCESS.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || state_q != ACCESS) begin
      wait_cnt_q <= '0;
    end else if (!pready_i) begin
      wait_cnt_q <= wait_cnt_q + TIMEOUT_CNT_WIDTH'(1);
    end
  end

  assign timeout_c = (wait_cnt_q == TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

  // Next state plus the response payload to present when entering RESP.
  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (be_err_c) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          state_d = RESP;
          err_d   = pslverr_i;
          rdata_d = (!pwrite_o && !pslverr_i) ? prdata_i : '0;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        else if (timeout_c) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; APB address/data stay put after a transfer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
    end else begin
      state_q   <= state_d;
      psel_o    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_o <= (state_d == ACCESS);
      rvalid_o  <= (state_d == RESP);
      rdata_o   <= rdata_d;
      err_o     <= err_d;
      if (gnt_o) begin
        paddr_o  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
        pwrite_o <= we_i;
        pwdata_o <= wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_obi_to_apb_bridge.sv
// Self-checking bench for obi_to_apb_bridge; covers APB_BRIDGE_TIMEOUT_EN when defined.
module tb_obi_to_apb_bridge;

  localparam int unsigned TB_TIMEOUT = 8;
`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned MAX_WAITS = 11;
`else
  localparam int unsigned MAX_WAITS = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [31:0] addr_i, wdata_i, rdata_o, paddr_o, pwdata_o, prdata_i;
  logic [3:0]  be_i;
  logic        pwrite_o, psel_o, penable_o, pready_i, pslverr_i;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  always #5 clk = ~clk;

  obi_to_apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .pwrite_o (pwrite_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (txn %0d): observed=0x%0h expected=0x%0h", tag, txn_id, obs, exp);
    end
  endtask

  // One transaction against a slave that raises pready after `waits` ACCESS cycles.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] srdata, input logic slverr);
    bit          be_err = we && (be != 4'hF);
    bit          timed_out = 1'b0;
    bit          access;
    int          acc, exp_rv, exp_psel, exp_pen;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_paddr = {addr[31:2], 2'b00};
    int          grant_cyc = -1, rv_cyc = -1, n_rv = 0, n_psel = 0, n_pen = 0;
    int          acc_seen = 0, bad_hold = 0, bad_idle = 0;
    logic [31:0] got_rdata = '0;
    logic        got_err = 1'b0;
    txn_id++;
`ifdef APB_BRIDGE_TIMEOUT_EN
    timed_out = !be_err && (waits >= int'(TB_TIMEOUT));
`endif
    if (be_err) begin
      exp_rv = 1; exp_psel = 0; exp_pen = 0; exp_rdata = '0; exp_err = 1'b1;
    end else if (timed_out) begin
      acc = int'(TB_TIMEOUT);
      exp_rv = 2 + acc; exp_psel = 1 + acc; exp_pen = acc; exp_rdata = '0; exp_err = 1'b1;
    end else begin
      acc = waits + 1;
      exp_rv = 2 + acc; exp_psel = 1 + acc; exp_pen = acc;
      exp_rdata = (!we && !slverr) ? srdata : 32'h0;
      exp_err = slverr;
    end

    addr_i = addr; we_i = we; be_i = be; wdata_i = wdata; req_i = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      access    = psel_o && penable_o;
      pready_i  = access ? (acc_seen == waits) : 1'($urandom_range(0, 1));
      prdata_i  = (access && acc_seen == waits) ? srdata : $urandom;
      pslverr_i = access ? slverr : 1'($urandom_range(0, 1));
      #1;
      if (gnt_o && grant_cyc < 0) grant_cyc = cyc;
      if (psel_o) begin
        n_psel++;
        if (paddr_o !== exp_paddr || pwrite_o !== we || (we && pwdata_o !== wdata)) bad_hold++;
      end
      if (penable_o) n_pen++;
      if (access) acc_seen++;
      if (rvalid_o) begin
        n_rv++;
        if (rv_cyc < 0) begin
          rv_cyc = cyc; got_rdata = rdata_o; got_err = err_o;
        end
      end else if (rdata_o !== 32'h0 || err_o !== 1'b0) begin
        bad_idle++;
      end
      @(negedge clk);
      if (grant_cyc >= 0) req_i = 1'b0;
      if (rv_cyc >= 0 && cyc >= rv_cyc + 2) break;
    end
    req_i = 1'b0;

    check("grant_cycle", grant_cyc, 0);
    check("rvalid_cycle", rv_cyc, exp_rv);
    check("rvalid_count", n_rv, 1);
    check("rdata", got_rdata, exp_rdata);
    check("err", got_err, exp_err);
    check("psel_cycles", n_psel, exp_psel);
    check("penable_cycles", n_pen, exp_pen);
    check("apb_stable", bad_hold, 0);
    check("resp_zero_when_idle", bad_idle, 0);
    if (!be_err) check("paddr_held", paddr_o, exp_paddr);
  endtask

  logic        we_r, sl_r;
  logic [3:0]  be_r;
  int          waits_r, n_late_rv;
  logic [15:0] gnt_mask, rv_mask;

  initial begin
    rst_n = 1'b0; req_i = 1'b1; addr_i = 32'hFFFF_FFFF; we_i = 1'b1; be_i = 4'hF;
    wdata_i = 32'hFFFF_FFFF; prdata_i = 32'hFFFF_FFFF; pready_i = 1'b1; pslverr_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_gnt", gnt_o, 0);
    check("reset_rvalid", rvalid_o, 0);
    check("reset_rdata", rdata_o, 0);
    check("reset_err", err_o, 0);
    check("reset_psel", psel_o, 0);
    check("reset_penable", penable_o, 0);
    check("reset_paddr", paddr_o, 0);
    check("reset_pwdata", pwdata_o, 0);
    check("reset_pwrite", pwrite_o, 0);
    req_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the plan.
    run_txn(32'h1A10_0004, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'h1A10_1000, 1'b1, 4'hF, 32'h0000_00FF, 3, 32'h5555_AAAA, 1'b0);
    run_txn(32'h1A10_1004, 1'b1, 4'h3, 32'h1234_5678, 0, 32'h0, 1'b0);
    run_txn(32'h1A10_0008, 1'b0, 4'hF, 32'h0, 1, 32'hCAFE_F00D, 1'b1);
    run_txn(32'h1A10_0007, 1'b0, 4'h0, 32'h0, 2, 32'h0BAD_C0DE, 1'b0);
    run_txn(32'h1A10_200C, 1'b1, 4'hF, 32'hA5A5_5A5A, 0, 32'h0, 1'b1);

    // Back-to-back zero-wait reads: grants every fourth cycle.
    addr_i = 32'h1A10_0010; we_i = 1'b0; be_i = 4'hF; req_i = 1'b1;
    pready_i = 1'b1; pslverr_i = 1'b0; prdata_i = 32'h1234_5678;
    gnt_mask = '0; rv_mask = '0;
    for (int c = 0; c < 12; c++) begin
      #1;
      gnt_mask[c] = gnt_o;
      rv_mask[c]  = rvalid_o;
      @(negedge clk);
    end
    req_i = 1'b0;
    check("b2b_gnt_pattern", gnt_mask, 16'h0111);
    check("b2b_rvalid_pattern", rv_mask, 16'h0888);
    repeat (4) @(negedge clk);

    // Reset applied in the middle of ACCESS.
    addr_i = 32'h1A10_2008; we_i = 1'b0; be_i = 4'hF; req_i = 1'b1; pready_i = 1'b0;
    @(negedge clk); req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_reset_in_access", penable_o, 1);
    rst_n = 1'b0; pready_i = 1'b1;
    @(negedge clk);
    #1;
    check("mid_reset_psel", psel_o, 0);
    check("mid_reset_penable", penable_o, 0);
    check("mid_reset_rvalid", rvalid_o, 0);
    rst_n = 1'b1;
    n_late_rv = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (rvalid_o) n_late_rv++;
    end
    check("mid_reset_no_rvalid", n_late_rv, 0);
    @(negedge clk);
    run_txn(32'h1A10_3000, 1'b0, 4'hF, 32'h0, 0, 32'h0F0F_0F0F, 1'b0);

`ifdef APB_BRIDGE_TIMEOUT_EN
    run_txn(32'h1A10_4000, 1'b0, 4'hF, 32'h0, 50, 32'h7777_7777, 1'b0);
    run_txn(32'h1A10_4004, 1'b0, 4'hF, 32'h0, 0, 32'h8888_8888, 1'b0);
    run_txn(32'h1A10_4008, 1'b0, 4'hF, 32'h0, int'(TB_TIMEOUT) - 1, 32'h9999_9999, 1'b0);
`endif

    // Randomized traffic against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      we_r    = 1'($urandom_range(0, 1));
      be_r    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      waits_r = int'($urandom_range(0, MAX_WAITS));
      sl_r    = ($urandom_range(0, 4) == 0);
      run_txn($urandom, we_r, be_r, $urandom, waits_r, $urandom, sl_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
